axis_stream_sink: RTL

- AXI4-Stream consumer placed directly downstream of the DMA MM2S stream output (m_axis_mm2s_*). It sinks the stream produced by the DMA data source.
- Buffers incoming beats in a small FIFO and drains them into a checker.
- The checker counts beats and packets, computes a per-packet additive checksum and compares data against an incrementing pattern.
- Used as the bench/SoC endpoint in place of the tie-off, so MM2S traffic can be measured.

---
 rtl/axis_stream_sink.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_stream_sink.sv
// axis_stream_sink: AXI4-Stream endpoint for the DMA MM2S output.
// Incoming beats are buffered in a small FIFO and drained into a checker.
// The checker counts beats and packets, builds a per-packet additive checksum
// and compares each beat against an incrementing pattern.
// Optional feature macro: AXIS_SINK_THROTTLE_EN adds a throttle[3:0] input that
// slows the drain to at most one pop every throttle+1 cycles.
module axis_stream_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          S_AXIS_ACLK,
  input  logic                          S_AXIS_ARESET,
  input  logic [DATA_WIDTH-1:0]         S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0]       S_AXIS_TSTRB,
  input  logic                          S_AXIS_TLAST,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  input  logic                          clear,
  input  logic                          check_en,
  input  logic [DATA_WIDTH-1:0]         expect_base,
`ifdef AXIS_SINK_THROTTLE_EN
  input  logic [3:0]                    throttle,
`endif
  output logic [CNT_WIDTH-1:0]          beat_count,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic [DATA_WIDTH-1:0]         last_checksum,
  output logic                          pkt_done,
  output logic                          mismatch,
  output logic [CNT_WIDTH-1:0]          err_beat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int LVL_WIDTH   = ADDR_WIDTH + 1;
  // The strobe travels with the beat so the pattern compare can mask the
  // expected value the same way the data was masked on entry.
  localparam int ENTRY_WIDTH = 1 + STRB_WIDTH + DATA_WIDTH;

  localparam logic [LVL_WIDTH-1:0]  LVL_ONE  = 1;
  localparam logic [LVL_WIDTH-1:0]  LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = 1;

  // Zero every byte whose strobe bit is low.
  function automatic logic [DATA_WIDTH-1:0] apply_strb(
    input logic [DATA_WIDTH-1:0] data,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      res[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : 8'h00;
    end
    return res;
  endfunction

  logic [ENTRY_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [LVL_WIDTH-1:0]   level_q;
  logic [LVL_WIDTH-1:0]   level_next;
  logic                   tready_q;
  logic                   push;
  logic                   pop;
  logic                   drain_ok;

  logic [ENTRY_WIDTH-1:0] rd_entry;
  logic [DATA_WIDTH-1:0]  pop_data;
  logic [STRB_WIDTH-1:0]  pop_strb;
  logic                   pop_last;
  logic [DATA_WIDTH-1:0]  expected_beat;
  logic                   beat_ok;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic [DATA_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0]  acc_sum;

  assign S_AXIS_TREADY = tready_q;
  assign fifo_level    = level_q;

  assign push = S_AXIS_TVALID & tready_q & ~clear;
  assign pop  = (level_q != '0) & drain_ok & ~clear;

  assign rd_entry      = mem[rd_ptr];
  assign pop_last      = rd_entry[ENTRY_WIDTH-1];
  assign pop_strb      = rd_entry[DATA_WIDTH +: STRB_WIDTH];
  assign pop_data      = rd_entry[DATA_WIDTH-1:0];
  assign expected_beat = apply_strb(expect_base + idx_q, pop_strb);
  assign beat_ok       = (pop_data == expected_beat);
  assign acc_sum       = acc_q + pop_data;

`ifdef AXIS_SINK_THROTTLE_EN
  logic [3:0] thr_cnt;

  assign drain_ok = (thr_cnt == 4'd0);

  // Drain throttle: reload on every pop, then count down to the next pop slot.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      thr_cnt <= 4'd0;
    end else if (clear) begin
      thr_cnt <= 4'd0;
    end else if (pop) begin
      thr_cnt <= throttle;
    end else if (thr_cnt != 4'd0) begin
      thr_cnt <= thr_cnt - 4'd1;
    end
  end
`else
  assign drain_ok = 1'b1;
`endif

  // Next FIFO occupancy; clear empties the FIFO outright.
  always_comb begin
    level_next = level_q;
    if (clear) begin
      level_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   level_next = level_q + LVL_ONE;
        2'b01:   level_next = level_q - LVL_ONE;
        default: level_next = level_q;
      endcase
    end
  end

  // FIFO storage write; the entry holds {last, strobe, masked data}.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (push) begin
      mem[wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TSTRB,
                      apply_strb(S_AXIS_TDATA, S_AXIS_TSTRB)};
    end
  end

  // FIFO pointers, level and the registered ready that looks at next level.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_ONE;
      end
      level_q  <= level_next;
      tready_q <= (level_next < LVL_FULL);
    end
  end

  // Checker: counts, checksum, pattern compare and packet completion pulse.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      beat_count    <= '0;
      pkt_count     <= '0;
      last_checksum <= '0;
      pkt_done      <= 1'b0;
      mismatch      <= 1'b0;
      err_beat      <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
    end else if (clear) begin
      beat_count    <= '0;
      pkt_count     <= '0;
      last_checksum <= '0;
      pkt_done      <= 1'b0;
      mismatch      <= 1'b0;
      err_beat      <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (pop) begin
        beat_count <= beat_count + CNT_ONE;
        if (check_en && !beat_ok) begin
          mismatch <= 1'b1;
          if (!mismatch) begin
            err_beat <= beat_count;
          end
        end
        if (pop_last) begin
          last_checksum <= acc_sum;
          acc_q         <= '0;
          idx_q         <= '0;
          pkt_count     <= pkt_count + CNT_ONE;
          pkt_done      <= 1'b1;
        end else begin
          acc_q <= acc_sum;
          idx_q <= idx_q + DATA_ONE;
        end
      end
    end
  end

endmodule
